// File: rtl/unidad_de_control_multiciclo_if.sv
// Control bus between the multicycle ARM controller and the calculator datapath.
// The controller uses the master modport; the datapath side uses the slave modport.
interface unidad_de_control_multiciclo_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUControl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [3:0]  state_o;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, state_o
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, state_o
    );
endinterface

// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle ARM control FSM: sequences FETCH..WB states, drives datapath selects/enables,
// holds the NZCV flags and the condition-pass bit latched in DECODE.
module unidad_de_control_multiciclo (
    input  logic                                  clk,
    input  logic                                  reset,
    unidad_de_control_multiciclo_if.master        bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state, w_next, w_view;
    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd_pc;
    logic       w_cond_ex;
    logic [1:0] w_dp_ctrl;
    logic       w_regw, w_memw, w_br, w_fetch;

    assign w_cond  = bus.Instr[19:16];
    assign w_op    = bus.Instr[15:14];
    assign w_funct = bus.Instr[13:8];
    assign w_rd_pc = (bus.Instr[3:0] == 4'hF);

    // Condition evaluation against the committed flags {N,Z,C,V}.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = r_flags;
        case (w_cond)
            4'h0:    w_cond_ex = z;
            4'h1:    w_cond_ex = ~z;
            4'h2:    w_cond_ex = c;
            4'h3:    w_cond_ex = ~c;
            4'h4:    w_cond_ex = n;
            4'h5:    w_cond_ex = ~n;
            4'h6:    w_cond_ex = v;
            4'h7:    w_cond_ex = ~v;
            4'h8:    w_cond_ex = c & ~z;
            4'h9:    w_cond_ex = ~c | z;
            4'hA:    w_cond_ex = (n == v);
            4'hB:    w_cond_ex = (n != v);
            4'hC:    w_cond_ex = ~z & (n == v);
            4'hD:    w_cond_ex = z | (n != v);
            4'hE:    w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        case (w_funct[4:1])
            4'b0100: w_dp_ctrl = 2'b00;
            4'b0010: w_dp_ctrl = 2'b01;
            4'b0000: w_dp_ctrl = 2'b10;
            4'b1100: w_dp_ctrl = 2'b11;
            default: w_dp_ctrl = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cond_ex <= w_cond_ex;
            if ((r_state == S_EXECUTER || r_state == S_EXECUTEI) && w_funct[0] && r_cond_ex)
                r_flags <= bus.ALUFlags;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // While reset is held the outputs show FETCH decoding with every enable forced low.
    assign w_view = reset ? S_FETCH : r_state;

    // NOTE: every output gets a default before the case so no latches are inferred.
    always_comb begin
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        w_regw         = 1'b0;
        w_memw         = 1'b0;
        w_br           = 1'b0;
        w_fetch        = 1'b0;
        case (w_view)
            S_FETCH: begin
                w_fetch       = 1'b1;
                bus.IRWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMADR: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = w_funct[3] ? 2'b00 : 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                w_regw        = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                w_memw     = 1'b1;
            end
            S_EXECUTER: bus.ALUControl = w_dp_ctrl;
            S_EXECUTEI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = w_dp_ctrl;
            end
            S_ALUWB:    w_regw = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                w_br          = 1'b1;
            end
            default: ;
        endcase
        if (reset)
            bus.IRWrite = 1'b0;
    end

    assign bus.MemWrite = ~reset & w_memw & r_cond_ex;
    assign bus.RegWrite = ~reset & w_regw & r_cond_ex & ~w_rd_pc;
    assign bus.PCWrite  = ~reset & (w_fetch | (w_br & r_cond_ex) | (w_regw & r_cond_ex & w_rd_pc));

    assign bus.ImmSrc = (w_op == 2'b01) ? 2'b10 : (w_op == 2'b10) ? 2'b01 : 2'b00;
    assign bus.RegSrc = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
    assign bus.state_o = r_state;
endmodule
